// File: rtl/reg_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_out_pkg
//  Description : Shared types and helpers for the output-register bank:
//                write/read address decode, CLR bit position and the
//                derived-parameter arithmetic (direction words, addr width).
//  Revision    : 1.0  initial release
// ============================================================================
package reg_out_pkg;

    // Bit of the 16-bit write word that requests a soft clear of the bank.
    localparam int c_clr_bit = 15;

    // Result of decoding a bus address against the register map.
    typedef enum logic [1:0] {
        DEC_DATA    = 2'd0,
        DEC_DIR     = 2'd1,
        DEC_INVALID = 2'd2
    } dec_e;

    // Number of DW-wide words needed to hold n_oe direction bits.
    function automatic int calc_dir_words(input int n_oe, input int dw);
        return (n_oe + dw - 1) / dw;
    endfunction

    // Address width covering data channels plus direction words (min 1).
    function automatic int calc_aw(input int n_ch, input int dir_words);
        return ((n_ch + dir_words) > 2) ? $clog2(n_ch + dir_words) : 1;
    endfunction

    // Data channels occupy 0..n_ch-1, direction words follow directly.
    function automatic dec_e decode_addr(input int addr, input int n_ch,
                                         input int dir_words);
        if (addr < n_ch)
            return DEC_DATA;
        else if (addr < n_ch + dir_words)
            return DEC_DIR;
        else
            return DEC_INVALID;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_out_bank_oe_seq.sv
`default_nettype none
// ============================================================================
//  Module      : oe_seq
//  Description : Break-before-make output-enable sequencer. An OE line is
//                the AND of its direction bit and that bit delayed by
//                1..OE_DLY cycles: OE falls with dir, rises OE_DLY cycles
//                after it, and short dir pulses never reach the pad.
//  Ports       : clk, rst (async, high), clr (sync history clear),
//                dir_in [N_OE] active direction, oe_out [N_OE] pad enables
//  Revision    : 1.0  initial release
// ============================================================================
module oe_seq #(
    parameter int N_OE   = 16,
    parameter int OE_DLY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [N_OE-1:0] dir_in,
    output logic [N_OE-1:0] oe_out
);

    logic [OE_DLY-1:0][N_OE-1:0] r_dly;
    logic [N_OE-1:0]             w_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dly[0] <= '0;
        else if (clr)
            r_dly[0] <= '0;
        else
            r_dly[0] <= dir_in;
    end

    generate
        for (genvar k = 1; k < OE_DLY; k++) begin : g_stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_dly[k] <= '0;
                else if (clr)
                    r_dly[k] <= '0;
                else
                    r_dly[k] <= r_dly[k-1];
            end
        end
    endgenerate

    // Direction must have been held for every delayed sample to enable.
    always_comb begin
        w_hist = '1;
        for (int k = 0; k < OE_DLY; k++)
            w_hist = w_hist & r_dly[k];
    end

    assign oe_out = dir_in & w_hist;

endmodule
`default_nettype wire

// File: rtl/reg_out_bank.sv
`default_nettype none
// ============================================================================
//  Module      : reg_out_bank
//  Description : Parametrised output-register bank. Addressed writes land
//                in shadow registers; a commit copies all shadows to the
//                active outputs in one edge. Supports readback of active
//                values, range-error flags, bus-carried soft clear (CLR) and
//                break-before-make OE sequencing.
//  Ports       : clk, rst (async, high)
//                wr_en/wr_addr/wr_data -> wr_err      write port
//                commit -> commit_ack                 shadow->active transfer
//                rd_en/rd_addr -> rd_data/rd_valid/rd_err   readback
//                data_out, dir_out, oe_out            pad-side outputs
//  Revision    : 1.0  initial release
// ============================================================================
module reg_out_bank
    import reg_out_pkg::*;
#(
    parameter int N_CH        = 16,
    parameter int DW          = 8,
    parameter int N_OE        = 16,
    parameter int OE_DLY      = 1,
    parameter int AUTO_COMMIT = 0,
    parameter int DIR_WORDS   = calc_dir_words(N_OE, DW),
    parameter int AW          = calc_aw(N_CH, DIR_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [15:0]          wr_data,
    output logic                 wr_err,
    input  logic                 commit,
    output logic                 commit_ack,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        rd_data,
    output logic                 rd_valid,
    output logic                 rd_err,
    output logic [N_CH*DW-1:0]   data_out,
    output logic [N_OE-1:0]      dir_out,
    output logic [N_OE-1:0]      oe_out
);

    localparam int                  c_dir_bits = DIR_WORDS * DW;
    // Direction storage is padded to whole words; bits >= N_OE stay 0.
    localparam logic [c_dir_bits-1:0] c_dir_mask =
        {c_dir_bits{1'b1}} >> (c_dir_bits - N_OE);

    logic [N_CH*DW-1:0]    r_data_sh, r_data_act, w_data_sh_nxt;
    logic [c_dir_bits-1:0] r_dir_sh,  r_dir_act,  w_dir_sh_nxt;

    logic  w_wr_clr, w_wr_ok, w_wr_bad, w_do_commit;
    dec_e  w_wr_dec, w_rd_dec;
    int    w_wr_idx, w_rd_idx;
    logic  w_unused_wr_data;

    assign w_wr_idx = int'(wr_addr);
    assign w_rd_idx = int'(rd_addr);
    assign w_wr_dec = decode_addr(w_wr_idx, N_CH, DIR_WORDS);
    assign w_rd_dec = decode_addr(w_rd_idx, N_CH, DIR_WORDS);

    // CLR ignores address and payload entirely.
    assign w_wr_clr = wr_en & wr_data[c_clr_bit];
    assign w_wr_ok  = wr_en & ~wr_data[c_clr_bit] & (w_wr_dec != DEC_INVALID);
    assign w_wr_bad = wr_en & ~wr_data[c_clr_bit] & (w_wr_dec == DEC_INVALID);

    // In auto mode every accepted write commits itself; commit is ignored.
    assign w_do_commit = (AUTO_COMMIT != 0) ? w_wr_ok : commit;

    // Only the CLR flag and payload bits carry meaning.
    assign w_unused_wr_data = &{1'b0, wr_data};

    // Next shadow value; committing this (rather than the current shadow)
    // makes a same-cycle write part of the commit.
    always_comb begin
        w_data_sh_nxt = r_data_sh;
        w_dir_sh_nxt  = r_dir_sh;
        if (w_wr_ok && (w_wr_dec == DEC_DATA))
            w_data_sh_nxt[w_wr_idx*DW +: DW] = wr_data[DW-1:0];
        if (w_wr_ok && (w_wr_dec == DEC_DIR))
            w_dir_sh_nxt[(w_wr_idx-N_CH)*DW +: DW] = wr_data[DW-1:0];
        w_dir_sh_nxt = w_dir_sh_nxt & c_dir_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_sh  <= '0;
            r_data_act <= '0;
            r_dir_sh   <= '0;
            r_dir_act  <= '0;
            commit_ack <= 1'b0;
            wr_err     <= 1'b0;
        end else if (w_wr_clr) begin
            // CLR beats a simultaneous commit and is not acknowledged.
            r_data_sh  <= '0;
            r_data_act <= '0;
            r_dir_sh   <= '0;
            r_dir_act  <= '0;
            commit_ack <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            r_data_sh  <= w_data_sh_nxt;
            r_dir_sh   <= w_dir_sh_nxt;
            if (w_do_commit) begin
                r_data_act <= w_data_sh_nxt;
                r_dir_act  <= w_dir_sh_nxt;
            end
            commit_ack <= w_do_commit;
            wr_err     <= w_wr_bad;
        end
    end

    // Readback samples the active registers before this edge's update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en & (w_rd_dec == DEC_INVALID);
            if (rd_en) begin
                case (w_rd_dec)
                    DEC_DATA: rd_data <= r_data_act[w_rd_idx*DW +: DW];
                    DEC_DIR:  rd_data <= r_dir_act[(w_rd_idx-N_CH)*DW +: DW];
                    default:  rd_data <= '0;
                endcase
            end
        end
    end

    assign data_out = r_data_act;
    assign dir_out  = r_dir_act[N_OE-1:0];

    oe_seq #(
        .N_OE   (N_OE),
        .OE_DLY (OE_DLY)
    ) u_oe_seq (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_wr_clr),
        .dir_in (dir_out),
        .oe_out (oe_out)
    );

endmodule
`default_nettype wire
